delta2_acc: RTL and testbench
=============================

# delta2_acc

Serial backpropagation stage computing the hidden-layer error term for one hidden neuron: delta2 = dadz2 × Σₖ (w3ₖ × delta3ₖ). It sits directly downstream of the output-layer delta3 units and consumes their results. Over N_OUT handshaked beats it receives (w3, delta3) pairs, accumulates them at full precision, scales by the hidden-layer sigmoid derivative, and emits a single 16-bit result with a one-cycle valid strobe. All data uses the codebase fixed-point format: signed 16-bit Q6.10, where 1.0 = 1024.

## Interface
- N_OUT, 3: number of output-layer neurons, i.e. beats per sum (≥1).
- ACC_W, 32+$clog2(N_OUT)+1: accumulator width in bits.

- clk  in  1  rising-edge clock.
- res  in  1  reset: asynchronous, active-high.
- start_i  in  1  begin an operation; sampled only in IDLE.
- dadz2_i  in  16  sigmoid derivative of this hidden neuron, Q6.10; latched on accepted start.
- in_valid_i  in  1  w3_i/delta3_i valid.
- w3_i  in  16  weight from this hidden neuron to output neuron k, Q6.10.
- delta3_i  in  16  delta3 of output neuron k, Q6.10.
- in_ready_o  out  1  pair accepted when in_valid_i & in_ready_o at the clock edge.
- busy_o  out  1  high in any state other than IDLE.
- delta2_o  out  16  result, Q6.10; holds its value until the next result.
- valid_o  out  1  one-cycle strobe: delta2_o is new.

## Operation
- States: IDLE, ACC, SCALE.
- IDLE:
  - in_ready_o=0.
  - start_i=1 latches dadz2_i into dadz2_q, clears acc and cnt, and moves to ACC.
  - in_valid_i is ignored.
- ACC:
  - in_ready_o=1 combinationally.
  - Each accepted beat: acc ← acc + sext(w3_i×delta3_i), where the product is a 32-bit signed value; cnt ← cnt+1.
  - Bubbles (in_valid_i=0) stall with no state change.
  - The beat with cnt=N_OUT−1 moves to SCALE.
- SCALE:
  - sum16 = acc[25:10], a truncation (floor; upper bits discarded, no saturation).
  - prod = sum16×dadz2_q, 32-bit signed.
  - On the edge: delta2_o ← prod[25:10], valid_o ← 1, state → IDLE.
- valid_o returns to 0 on the next edge.
- start_i outside IDLE is ignored and not queued.
- Arithmetic: signed throughout. The accumulator must not overflow for N_OUT full-scale products. Wrap in the [25:10] selection is intended behaviour.
- Reset state (asynchronous, immediate): IDLE, acc=0, cnt=0, dadz2_q=0, delta2_o=0, valid_o=0, in_ready_o=0, busy_o=0.
- Reset mid-operation abandons the operation. No valid_o is produced for it.

## Timing
- Edge E0 samples start. With continuous in_valid_i, pairs are accepted on edges E1..E_N.
- SCALE occupies the cycle after E_N. Edge E_{N+1} registers delta2_o, and valid_o is high for the cycle after E_{N+1}.
- Latency from start to valid_o is N_OUT+2 edges, plus one per bubble. For the default this is 5 cycles.
- A new start may be sampled on the edge that ends the valid_o cycle, giving back-to-back throughput of one result per N_OUT+2 cycles.
- The output register is updated only in SCALE.

## Test plan
- Nominal:
  - Stimulus: start with dadz2=256; pairs (1024,512), (512,1024), (−1024,256), in_valid continuous.
  - Required: acc=786432, sum16=768, delta2_o=192, valid_o high exactly one cycle after the 5th edge.
- Bubbles:
  - Stimulus: same data with in_valid low for 2 cycles between beats 1 and 2.
  - Required: delta2_o=192, valid_o delayed by exactly 2 cycles, in_ready_o high throughout ACC.
- Negative/floor:
  - Stimulus: pairs (−1024,1), (0,0), (0,0); dadz2=1024.
  - Required: sum16=−1, delta2_o=0xFFFF.
- Wrap:
  - Stimulus: three pairs (8192,8192); dadz2=1024.
  - Required: acc=201326592, delta2_o=0 (bits [25:10] clear).
- Reset/protocol:
  - Stimulus: assert res asynchronously after beat 2; release; run nominal.
  - Required: outputs go to reset values immediately, no valid_o from the aborted run, and the nominal result of 192 follows.
  - Stimulus: start pulses during ACC/SCALE and in_valid in IDLE.
  - Required: no effect.

Source files
------------

// File: rtl/delta2_acc.sv
// rtl/delta2_acc.sv - hidden-layer delta2: sum of w3*delta3 over N_OUT beats, scaled by dadz2
module delta2_acc #(
  parameter int N_OUT = 3,
  parameter int ACC_W = 32 + $clog2(N_OUT) + 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start_i,
  input  logic [15:0] dadz2_i,
  input  logic        in_valid_i,
  input  logic [15:0] w3_i,
  input  logic [15:0] delta3_i,
  output logic        in_ready_o,
  output logic        busy_o,
  output logic [15:0] delta2_o,
  output logic        valid_o
);

  localparam int CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_dadz2;
  logic [15:0]        r_delta2;
  logic               r_valid;

  logic               w_last;
  logic [31:0]        w_prod;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [15:0]        w_sum16;
  logic [31:0]        w_scaled;
  logic               w_unused_bits;

  // Operands are sign-extended to 32 bits so the low 32 bits of the product are the signed product.
  assign w_prod     = {{16{w3_i[15]}}, w3_i} * {{16{delta3_i[15]}}, delta3_i};
  assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
  assign w_last     = (r_cnt == CNT_W'(N_OUT - 1));

  // Back to Q6.10 by truncation; bits above 25 are dropped on purpose (wrap, no saturation).
  assign w_sum16  = r_acc[25:10];
  assign w_scaled = {{16{w_sum16[15]}}, w_sum16} * {{16{r_dadz2[15]}}, r_dadz2};

  assign w_unused_bits = ^{w_scaled[31:26], w_scaled[9:0], r_acc[ACC_W-1:26], r_acc[9:0]};

  assign delta2_o = r_delta2;
  assign valid_o  = r_valid;

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_nx = r_state;
    in_ready_o = 1'b0;
    busy_o     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_nx = S_ACC;
      end
      S_ACC: begin
        in_ready_o = 1'b1;
        if (in_valid_i && w_last) w_state_nx = S_SCALE;
      end
      S_SCALE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath: latch dadz2 on start, accumulate accepted beats, register the scaled result.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_dadz2  <= '0;
      r_delta2 <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_dadz2 <= dadz2_i;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ACC: begin
          if (in_valid_i) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SCALE: begin
          r_delta2 <= w_scaled[25:10];
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delta2_acc.sv
// tb/tb_delta2_acc.sv - randomized bench for delta2_acc against an arithmetic reference model
module tb_delta2_acc;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        res;
  logic        start_i;
  logic [15:0] dadz2_i;
  logic        in_valid_i;
  logic [15:0] w3_i;
  logic [15:0] delta3_i;
  logic        in_ready_o;
  logic        busy_o;
  logic [15:0] delta2_o;
  logic        valid_o;

  delta2_acc #(.N_OUT(N)) u_dut (
    .clk       (clk),
    .res       (res),
    .start_i   (start_i),
    .dadz2_i   (dadz2_i),
    .in_valid_i(in_valid_i),
    .w3_i      (w3_i),
    .delta3_i  (delta3_i),
    .in_ready_o(in_ready_o),
    .busy_o    (busy_o),
    .delta2_o  (delta2_o),
    .valid_o   (valid_o)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_hold = 16'h0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] pw[N];
  logic [15:0] pd[N];
  int          bub[N];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // Reference: exact integer sum, floor to Q6.10 mod 2^16, multiply, floor again mod 2^16.
  function automatic logic [15:0] model(input logic [15:0] d, output longint acc,
                                        output logic [15:0] s16);
    longint prod;
    acc = 0;
    for (int k = 0; k < N; k++)
      acc += longint'($signed(pw[k])) * longint'($signed(pd[k]));
    s16  = 16'(acc >>> 10);
    prod = longint'($signed(s16)) * longint'($signed(d));
    return 16'(prod >>> 10);
  endfunction

  // Every cycle: valid_o only on predicted cycles, delta2_o new there and held otherwise.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < edge_n) begin
      chk("valid_missing_cycle", edge_n, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == edge_n) begin
      chk("valid_strobe", valid_o, 1);
      chk("delta2_value", delta2_o, q[0].val);
      exp_hold = q[0].val;
      void'(q.pop_front());
    end else begin
      chk("valid_idle", valid_o, 0);
      chk("delta2_hold", delta2_o, exp_hold);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      chk("idle_busy", busy_o, 0);
      chk("idle_ready", in_ready_o, 0);
      start_i    = 1'b0;
      in_valid_i = 1'($urandom_range(0, 1));
      w3_i       = 16'($urandom);
      delta3_i   = 16'($urandom);
      @(negedge clk);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the valid_o cycle.
  task automatic run_op(input logic [15:0] d, output int m);
    int          tot;
    longint      a;
    logic [15:0] s;
    exp_t        e;
    tot = 0;
    for (int k = 0; k < N; k++) tot += bub[k];
    e.val      = model(d, a, s);
    m          = edge_n;
    e.cyc      = m + N + 2 + tot;
    q.push_back(e);
    start_i    = 1'b1;
    dadz2_i    = d;
    in_valid_i = 1'($urandom_range(0, 1));
    w3_i       = 16'($urandom);
    delta3_i   = 16'($urandom);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      for (int b = 0; b < bub[k]; b++) begin
        chk("acc_ready_bubble", in_ready_o, 1);
        chk("acc_busy_bubble", busy_o, 1);
        start_i    = 1'($urandom_range(0, 1));
        dadz2_i    = 16'($urandom);
        in_valid_i = 1'b0;
        w3_i       = 16'($urandom);
        delta3_i   = 16'($urandom);
        @(negedge clk);
      end
      chk("acc_ready", in_ready_o, 1);
      chk("acc_busy", busy_o, 1);
      start_i    = 1'($urandom_range(0, 1));
      dadz2_i    = 16'($urandom);
      in_valid_i = 1'b1;
      w3_i       = pw[k];
      delta3_i   = pd[k];
      @(negedge clk);
    end
    chk("scale_ready", in_ready_o, 0);
    chk("scale_busy", busy_o, 1);
    start_i    = 1'($urandom_range(0, 1));
    in_valid_i = 1'($urandom_range(0, 1));
    w3_i       = 16'($urandom);
    delta3_i   = 16'($urandom);
    @(negedge clk);
    chk("done_busy", busy_o, 0);
    chk("done_ready", in_ready_o, 0);
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic set_nominal();
    pw[0] = 16'd1024;  pd[0] = 16'd512;
    pw[1] = 16'd512;   pd[1] = 16'd1024;
    pw[2] = 16'hFC00;  pd[2] = 16'd256;
    for (int k = 0; k < N; k++) bub[k] = 0;
  endtask

  function automatic logic [15:0] rnd_word();
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel == 0) return 16'h8000;
    if (sel == 1) return 16'h7FFF;
    if (sel == 2) return 16'h0000;
    return 16'($urandom);
  endfunction

  initial begin
    int          m;
    longint      a;
    logic [15:0] s;
    logic [15:0] r;

    res        = 1'b1;
    start_i    = 1'b0;
    dadz2_i    = 16'h0;
    in_valid_i = 1'b0;
    w3_i       = 16'h0;
    delta3_i   = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_valid", valid_o, 0);
    chk("reset_delta2", delta2_o, 0);
    chk("reset_ready", in_ready_o, 0);
    chk("reset_busy", busy_o, 0);
    res = 1'b0;
    idle(2);

    // Nominal: model pinned by hand, then DUT.
    set_nominal();
    r = model(16'd256, a, s);
    chk("model_nom_acc", a, 786432);
    chk("model_nom_sum16", longint'($signed(s)), 768);
    chk("model_nom_delta2", r, 192);
    run_op(16'd256, m);
    chk("nom_delta2", delta2_o, 192);
    chk("nom_valid", valid_o, 1);
    chk("nom_latency", edge_n - m, 5);
    idle(2);

    // Two bubbles between beats 1 and 2.
    set_nominal();
    bub[1] = 2;
    run_op(16'd256, m);
    chk("bubble_delta2", delta2_o, 192);
    chk("bubble_latency", edge_n - m, 7);
    idle(1);

    // Negative sum floors to -1.
    pw[0] = 16'hFC00; pd[0] = 16'd1;
    pw[1] = 16'd0;    pd[1] = 16'd0;
    pw[2] = 16'd0;    pd[2] = 16'd0;
    for (int k = 0; k < N; k++) bub[k] = 0;
    r = model(16'd1024, a, s);
    chk("model_neg_sum16", longint'($signed(s)), -1);
    chk("model_neg_delta2", r, 16'hFFFF);
    run_op(16'd1024, m);
    chk("neg_delta2", delta2_o, 16'hFFFF);
    idle(1);

    // Wrap in the [25:10] selection.
    for (int k = 0; k < N; k++) begin
      pw[k] = 16'd8192; pd[k] = 16'd8192; bub[k] = 0;
    end
    r = model(16'd1024, a, s);
    chk("model_wrap_acc", a, 201326592);
    chk("model_wrap_delta2", r, 0);
    run_op(16'd1024, m);
    chk("wrap_delta2", delta2_o, 0);
    idle(1);

    // Reset asserted asynchronously after beat 2, then a nominal run.
    set_nominal();
    start_i = 1'b1;
    dadz2_i = 16'd256;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_i = 1'b1;
      w3_i       = pw[k];
      delta3_i   = pd[k];
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    #2;
    res = 1'b1;
    q.delete();
    exp_hold = 16'h0;
    #1;
    chk("abort_valid", valid_o, 0);
    chk("abort_delta2", delta2_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", in_ready_o, 0);
    @(negedge clk);
    res = 1'b0;
    idle(6);
    set_nominal();
    run_op(16'd256, m);
    chk("post_reset_delta2", delta2_o, 192);
    idle(1);

    // Randomized operations with bubbles and back-to-back starts.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        pw[k]  = rnd_word();
        pd[k]  = rnd_word();
        bub[k] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
      end
      run_op(rnd_word(), m);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
